// File: rtl/leb128_result_encoder.sv
// leb128_result_encoder: serialises one typed stack value into WebAssembly immediate bytes.
// Ports: clk, reset (async active-low); in_valid/in_ready/in_data[63:0]/in_type[1:0]/in_signed
// accept a value; out_valid/out_ready/out_data[7:0]/out_last emit one byte per cycle;
// err pulses when a 64-bit type is offered with USE_64B=0.
// in_type encoding: 0 = i32, 1 = i64, 2 = f32, 3 = f64 (bit0 = 64-bit, bit1 = float).
module leb128_result_encoder #(
  parameter int USE_64B = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_type,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        err
);
  localparam logic NO64 = (USE_64B == 0);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_next;
  logic [63:0] v, r;
  logic [3:0]  cnt;
  logic        flt, sgn, wide, leb_done;
  always_comb begin
    r = sgn ? $unsigned($signed(v) >>> 7) : v >> 7;
    leb_done = sgn ? ((r == 64'd0 && !v[6]) || (&r && v[6])) : (r == 64'd0);
    // byte counter caps the LEB128 length at 5 (i32) / 10 (i64) bytes
    out_last = (state == EMIT) && (flt ? (cnt == (wide ? 4'd7 : 4'd3))
                                       : (leb_done || cnt == (wide ? 4'd9 : 4'd4)));
    out_data = (state == EMIT) ? (flt ? v[7:0] : {~out_last, v[6:0]}) : 8'h00;
    out_valid = (state == EMIT);
    in_ready = (state == IDLE);
    state_next = state;
    if (state == IDLE && in_valid && !(in_type[0] && NO64))
      state_next = EMIT;
    else if (state == EMIT && out_ready && out_last)
      state_next = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
      cnt <= '0;
      flt <= 1'b0;
      sgn <= 1'b0;
      wide <= 1'b0;
      err <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      err <= in_type[0] && NO64;
      v <= (in_type == 2'd0) ? (in_signed ? {{32{in_data[31]}}, in_data[31:0]} : {32'd0, in_data[31:0]})
                             : in_data;
      cnt <= '0;
      flt <= in_type[1];
      sgn <= in_signed && !in_type[1];
      wide <= in_type[0];
    end else begin
      err <= 1'b0;
      if (state == EMIT && out_ready) begin
        v <= flt ? v >> 8 : r;
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_leb128_result_encoder.sv
// tb_leb128_result_encoder: scoreboard bench for leb128_result_encoder (64-bit and 32-bit-only builds).
module tb_leb128_result_encoder;
  localparam logic [1:0] I32 = 2'd0, I64 = 2'd1, F32 = 2'd2, F64 = 2'd3;
  logic clk = 0, reset = 0;
  logic in_valid = 0, in_signed = 0, out_ready = 1;
  logic [63:0] in_data = '0;
  logic [1:0]  in_type = '0;
  logic in_ready, out_valid, out_last, err;
  logic [7:0] out_data;
  logic in_valid2 = 0, in_ready2, out_valid2, out_last2, err2;
  logic [7:0] out_data2;
  logic [8:0] q[$];
  int tests = 0, fails = 0, err2_cnt = 0, ov2_cnt = 0;

  leb128_result_encoder #(.USE_64B(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_type(in_type), .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .err(err));

  leb128_result_encoder #(.USE_64B(0)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .in_type(in_type), .in_signed(in_signed), .out_valid(out_valid2), .out_ready(1'b1),
    .out_data(out_data2), .out_last(out_last2), .err(err2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err2) err2_cnt++;
    if (out_valid2) ov2_cnt++;
    if (reset && out_valid && out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_byte: got %02h last=%0b, none expected", out_data, out_last);
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        if ({out_data, out_last} !== e) begin
          fails++;
          $display("FAIL byte: got %02h last=%0b, expected %02h last=%0b", out_data, out_last, e[8:1], e[0]);
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_bytes(input logic [7:0] b[$]);
    foreach (b[i]) q.push_back({b[i], i == b.size() - 1});
  endtask

  task automatic offer(logic [63:0] d, logic [1:0] t, logic s);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("offer_ready", in_ready, 1);
    in_data = d; in_type = t; in_signed = s; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({name, "_idle"}, in_ready, 1);
    check({name, "_drained"}, q.size(), 0);
  endtask

  task automatic run(string name, logic [63:0] d, logic [1:0] t, logic s, input logic [7:0] b[$]);
    expect_bytes(b);
    offer(d, t, s);
    wait_idle(name);
  endtask

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1 reset = 1;

    // case 1 with back-to-back timing check
    expect_bytes('{8'hE5, 8'h8E, 8'h26});
    offer(64'd624485, I32, 0);
    for (int i = 0; i < 3; i++) begin @(negedge clk); check("c1_valid", out_valid, 1); end
    @(negedge clk);
    check("c1_done_valid", out_valid, 0);
    check("c1_done_ready", in_ready, 1);
    check("c1_drained", q.size(), 0);

    run("s_neg", 64'hFFFF_FFFF_FFFE_1DC0 & 64'hFFFF_FFFF, I32, 1, '{8'hC0, 8'hBB, 8'h78});
    run("s_m1", 64'hFFFF_FFFF, I32, 1, '{8'h7F});
    run("s_64", 64'd64, I32, 1, '{8'hC0, 8'h00});
    run("u_zero", 64'hDEAD_BEEF_0000_0000, I32, 0, '{8'h00});
    run("u_max32", 64'hFFFF_FFFF, I32, 0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F});
    run("s_min32", 64'h8000_0000, I32, 1, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h78});
    run("u_max64", 64'hFFFF_FFFF_FFFF_FFFF, I64, 0,
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01});
    run("s_min64", 64'h8000_0000_0000_0000, I64, 1,
        '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F});
    run("f32", 64'h1234_5678_C000_0000, F32, 1, '{8'h00, 8'h00, 8'h00, 8'hC0});
    run("f64", 64'h4000_0000_0000_0000, F64, 0,
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40});

    // backpressure on byte 1
    expect_bytes('{8'hE5, 8'h8E, 8'h26});
    offer(64'd624485, I32, 0);
    @(posedge clk); #1 out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'h8E);
      check("bp_last", out_last, 0);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    wait_idle("bp");

    // reset during byte 1 of the 10-byte value
    expect_bytes('{8'hFF});
    q[0][0] = 1'b0;
    offer(64'hFFFF_FFFF_FFFF_FFFF, I64, 0);
    @(posedge clk); #1;
    check("mid_byte1", out_data, 8'hFF);
    reset = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("mid_after_valid", out_valid, 0);
    check("mid_after_ready", in_ready, 1);
    check("mid_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    check("mid_quiet", out_valid, 0);

    // 32-bit-only build rejects i64
    check("n64_ready", in_ready2, 1);
    in_data = 64'd5; in_type = I64; in_signed = 0; in_valid2 = 1;
    @(posedge clk); #1 in_valid2 = 0;
    repeat (4) @(negedge clk);
    check("n64_err_pulses", err2_cnt, 1);
    check("n64_no_out", ov2_cnt, 0);
    check("n64_ready_after", in_ready2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
